// File: rtl/spi_master_pkg.sv
// Shared SPI master types and constants: TX state encoding, data/counter widths, reset target.
package spi_master_pkg;

   localparam int SPI_DATA_W = 32;
   localparam int SPI_CNT_W  = 16;

   localparam logic [SPI_CNT_W-1:0] SPI_CNT_RST = 16'h8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRANSMIT  = 2'd1,
      WAIT_FIFO = 2'd2
   } tx_state_t;

endpackage

// File: rtl/spi_master_tx.sv
// SPI TX shifter: MSB-first, 1 bit or 1 nibble per tx_edge; first bit on the line one cycle after the pop.
// Stalls in WAIT_FIFO with clk_en_o low whenever a word boundary meets an empty FIFO.
module spi_master_tx
   import spi_master_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic        tx_edge,
   output logic        tx_done,
   output logic        sdo0,
   output logic        sdo1,
   output logic        sdo2,
   output logic        sdo3,
   input  logic        en_quad_in,
   input  logic [15:0] counter_in,
   input  logic        counter_in_upd,
   input  logic [31:0] data,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        clk_en_o
);

   tx_state_t             state, state_nxt;
   logic [SPI_CNT_W-1:0]  counter, counter_nxt;
   logic [SPI_CNT_W-1:0]  counter_trgt, counter_trgt_nxt;
   logic [SPI_CNT_W-1:0]  trgt_m1;
   logic [SPI_DATA_W-1:0] data_int, data_int_nxt, data_shifted;
   logic                  word_end, last;

   assign trgt_m1      = counter_trgt - 16'd1;
   assign word_end     = (!en_quad_in && (counter[4:0] == 5'h1F)) ||
                         ( en_quad_in && (counter[2:0] == 3'h7));
   assign last         = tx_edge && (counter == trgt_m1);
   assign data_shifted = en_quad_in ? {data_int[27:0], 4'h0} : {data_int[30:0], 1'b0};

   assign sdo0 = en_quad_in ? data_int[28] : data_int[31];
   assign sdo1 = en_quad_in & data_int[29];
   assign sdo2 = en_quad_in & data_int[30];
   assign sdo3 = en_quad_in & data_int[31];

   // Quad transfers count nibbles, so the bit length is divided by four.
   always_comb begin
      counter_trgt_nxt = counter_trgt;
      if (counter_in_upd) begin
         counter_trgt_nxt = en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         counter      <= '0;
         counter_trgt <= SPI_CNT_RST;
         data_int     <= '0;
      end else begin
         state        <= state_nxt;
         counter      <= counter_nxt;
         counter_trgt <= counter_trgt_nxt;
         data_int     <= data_int_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      counter_nxt  = counter;
      data_int_nxt = data_int;
      tx_done      = 1'b0;
      data_ready   = 1'b0;
      clk_en_o     = 1'b0;
      unique case (state)
         IDLE: begin
            // A zero-length request completes at once without touching the FIFO.
            if (counter_trgt == '0) begin
               tx_done = en;
            end else begin
               data_ready = en;
               if (en && data_valid) begin
                  data_int_nxt = data;
                  counter_nxt  = '0;
                  state_nxt    = TRANSMIT;
               end
            end
         end
         TRANSMIT: begin
            clk_en_o = 1'b1;
            if (tx_edge) begin
               counter_nxt  = counter + 16'd1;
               data_int_nxt = data_shifted;
               if (last) begin
                  tx_done     = 1'b1;
                  counter_nxt = '0;
                  state_nxt   = IDLE;
               end else if (word_end) begin
                  data_ready = 1'b1;
                  if (data_valid) begin
                     data_int_nxt = data;
                  end else begin
                     clk_en_o  = 1'b0;
                     state_nxt = WAIT_FIFO;
                  end
               end
            end
         end
         WAIT_FIFO: begin
            data_ready = 1'b1;
            if (data_valid) begin
               data_int_nxt = data;
               state_nxt    = TRANSMIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: a queue-backed FIFO feeds words, expected symbols are queued at push time.
module tb_spi_master_tx;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic        tx_edge = 1'b0;
   logic        tx_done;
   logic        sdo0, sdo1, sdo2, sdo3;
   logic        en_quad_in = 1'b0;
   logic [15:0] counter_in = 16'd0;
   logic        counter_in_upd = 1'b0;
   logic [31:0] data = 32'd0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic        clk_en_o;

   logic [31:0] fifo_q[$];
   logic [3:0]  exp_q[$];
   int          pops = 0;
   int          checks = 0;
   int          failures = 0;

   spi_master_tx dut (
      .clk(clk), .rstn(rstn), .en(en), .tx_edge(tx_edge), .tx_done(tx_done),
      .sdo0(sdo0), .sdo1(sdo1), .sdo2(sdo2), .sdo3(sdo3),
      .en_quad_in(en_quad_in), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
      .data(data), .data_valid(data_valid), .data_ready(data_ready), .clk_en_o(clk_en_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic fifo_refresh();
      data_valid = (fifo_q.size() != 0);
      if (data_valid) data = fifo_q[0];
      else data = 32'd0;
   endtask

   task automatic fifo_push(input logic [31:0] w);
      fifo_q.push_back(w);
      fifo_refresh();
   endtask

   // Advance one clock; the handshake is sampled on the falling edge and the pop applied after the rising edge.
   task automatic tick();
      logic pop;
      @(negedge clk);
      pop = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (pop) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      fifo_refresh();
   endtask

   task automatic exp_std(input logic [31:0] w, input int nbits);
      for (int k = 0; k < nbits; k++) exp_q.push_back({3'b000, w[31-k]});
   endtask

   task automatic exp_quad(input logic [31:0] w, input int nnib);
      logic [31:0] t;
      t = w;
      for (int k = 0; k < nnib; k++) begin
         exp_q.push_back(t[31:28]);
         t = t << 4;
      end
   endtask

   task automatic set_target(input logic [15:0] len, input logic quad);
      en_quad_in     = quad;
      counter_in     = len;
      counter_in_upd = 1'b1;
      tick();
      counter_in_upd = 1'b0;
   endtask

   task automatic start_transfer();
      en = 1'b1;
      tick();
      en = 1'b0;
   endtask

   // Consumes one scoreboard symbol per edge and checks tx_done against the expected last edge.
   task automatic run_edges(input int n, input logic done_last, input string name,
                            output logic en_last, output logic rdy_last);
      logic [3:0] sym, expv;
      logic       exp_done;
      en_last  = 1'b0;
      rdy_last = 1'b0;
      for (int i = 0; i < n; i++) begin
         sym = {sdo3, sdo2, sdo1, sdo0};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sdo: edge %0d got %h, scoreboard empty", name, i, sym);
         end else begin
            expv = exp_q.pop_front();
            if (sym !== expv) begin
               failures++;
               $display("FAIL %s_sdo: edge %0d got %h expected %h", name, i, sym, expv);
            end
         end
         tx_edge = 1'b1;
         #1;
         exp_done = done_last && (i == n - 1);
         checks++;
         if (tx_done !== exp_done) begin
            failures++;
            $display("FAIL %s_done: edge %0d got %b expected %b", name, i, tx_done, exp_done);
         end
         en_last  = clk_en_o;
         rdy_last = data_ready;
         tick();
         tx_edge = 1'b0;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({tx_done, data_ready, clk_en_o, sdo3, sdo2, sdo1, sdo0} !== 7'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {tx_done, data_ready, clk_en_o, sdo3, sdo2, sdo1, sdo0});
      end
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_std8();
      logic el, rl;
      int   p0;
      p0 = pops;
      set_target(16'd8, 1'b0);
      fifo_push(32'hA500_0000);
      exp_std(32'hA500_0000, 8);
      start_transfer();
      run_edges(8, 1'b1, "std8", el, rl);
      checks++;
      if (clk_en_o !== 1'b0) begin
         failures++;
         $display("FAIL std8_idle_clk_en: got %b expected 0", clk_en_o);
      end
      checks++;
      if (pops - p0 != 1) begin
         failures++;
         $display("FAIL std8_pops: got %0d expected 1", pops - p0);
      end
   endtask

   task automatic test_quad();
      logic el, rl;
      int   p0;
      p0 = pops;
      set_target(16'd32, 1'b1);
      fifo_push(32'h1234_5678);
      exp_quad(32'h1234_5678, 8);
      start_transfer();
      run_edges(8, 1'b1, "quad", el, rl);
      checks++;
      if (pops - p0 != 1) begin
         failures++;
         $display("FAIL quad_pops: got %0d expected 1", pops - p0);
      end
      en_quad_in = 1'b0;
   endtask

   task automatic test_stall();
      logic el, rl;
      int   p0;
      p0 = pops;
      set_target(16'd64, 1'b0);
      fifo_push(32'hC3A5_0F96);
      exp_std(32'hC3A5_0F96, 32);
      start_transfer();
      run_edges(32, 1'b0, "stall_w1", el, rl);
      checks++;
      if ({el, rl} !== 2'b01) begin
         failures++;
         $display("FAIL stall_edge32: clk_en/ready got %b expected 01", {el, rl});
      end
      // Edges while stalled must not advance anything.
      tx_edge = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      tx_edge = 1'b0;
      checks++;
      if ({clk_en_o, data_ready} !== 2'b01) begin
         failures++;
         $display("FAIL stall_wait: clk_en/ready got %b expected 01", {clk_en_o, data_ready});
      end
      fifo_push(32'h6B1E_D247);
      exp_std(32'h6B1E_D247, 32);
      tick();
      run_edges(32, 1'b1, "stall_w2", el, rl);
      checks++;
      if (pops - p0 != 2) begin
         failures++;
         $display("FAIL stall_pops: got %0d expected 2", pops - p0);
      end
   endtask

   task automatic test_back_to_back();
      logic el, rl;
      int   p0;
      p0 = pops;
      set_target(16'd40, 1'b0);
      fifo_push(32'hFFFF_FFFF);
      fifo_push(32'h8000_0000);
      exp_std(32'hFFFF_FFFF, 32);
      exp_std(32'h8000_0000, 8);
      start_transfer();
      run_edges(32, 1'b0, "b2b_w1", el, rl);
      checks++;
      if ({el, rl} !== 2'b11) begin
         failures++;
         $display("FAIL b2b_reload: clk_en/ready got %b expected 11", {el, rl});
      end
      run_edges(8, 1'b1, "b2b_w2", el, rl);
      checks++;
      if (pops - p0 != 2 || fifo_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_pops: got %0d left %0d expected 2 left 0", pops - p0, fifo_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic el, rl;
      set_target(16'd32, 1'b0);
      fifo_push(32'hFFFF_FFFF);
      exp_std(32'hFFFF_FFFF, 32);
      start_transfer();
      run_edges(5, 1'b0, "rstmid", el, rl);
      rstn = 1'b0;
      #1;
      checks++;
      if ({tx_done, data_ready, clk_en_o, sdo3, sdo2, sdo1, sdo0} !== 7'd0) begin
         failures++;
         $display("FAIL rstmid_outputs: got %b expected 0000000",
                  {tx_done, data_ready, clk_en_o, sdo3, sdo2, sdo1, sdo0});
      end
      exp_q.delete();
      tick();
      rstn = 1'b1;
      tick();
      fifo_push(32'hA500_0000);
      exp_std(32'hA500_0000, 8);
      start_transfer();
      run_edges(8, 1'b1, "rstmid_restart", el, rl);
   endtask

   task automatic test_zero_len();
      int p0;
      p0 = pops;
      set_target(16'd0, 1'b0);
      fifo_push(32'hDEAD_BEEF);
      en = 1'b1;
      #1;
      checks++;
      if ({tx_done, data_ready, clk_en_o} !== 3'b100) begin
         failures++;
         $display("FAIL zero_len_pulse: done/ready/clk_en got %b expected 100",
                  {tx_done, data_ready, clk_en_o});
      end
      tick();
      en = 1'b0;
      #1;
      checks++;
      if (pops != p0 || fifo_q.size() != 1 || {tx_done, clk_en_o} !== 2'b00) begin
         failures++;
         $display("FAIL zero_len_after: pops %0d left %0d done/clk_en %b expected 0 1 00",
                  pops - p0, fifo_q.size(), {tx_done, clk_en_o});
      end
      fifo_q.delete();
      fifo_refresh();
   endtask

   initial begin
      test_reset();
      test_std8();
      test_quad();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_zero_len();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
